// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts one command byte plus odd parity out on device clock falls, then checks the ack.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_error,
   output logic       busy,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE, INHIBIT, RELEASE, SEND, ACK, WAIT_IDLE, DONE, FAIL
   } state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic                   clk_s, data_s, clk_prev, fe;
   logic [INH_W-1:0]       inh_cnt;
   logic [TO_W-1:0]        to_cnt;
   logic [3:0]             idx;
   logic [8:0]             shift;
   logic                   data_bit;
   logic                   inh_last, timeout;

   // Idle bus level is high, so the synchronisers reset to 1 to avoid a false edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
         clk_prev  <= clk_s;
      end
   end

   assign clk_s    = clk_sync[SYNC_STAGES-1];
   assign data_s   = data_sync[SYNC_STAGES-1];
   assign fe       = clk_prev & ~clk_s;
   assign inh_last = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
   assign timeout  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      tx_ready    = 1'b0;
      busy        = 1'b1;
      tx_done     = 1'b0;
      tx_error    = 1'b0;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      case (state)
         IDLE: begin
            tx_ready = 1'b1;
            busy     = 1'b0;
            if (tx_valid) state_next = INHIBIT;
         end
         INHIBIT: begin
            ps2_clk_oe  = 1'b1;
            ps2_data_oe = inh_last;
            if (inh_last) state_next = RELEASE;
         end
         RELEASE: begin
            ps2_data_oe = 1'b1;
            state_next  = SEND;
         end
         SEND: begin
            ps2_data_oe = data_bit;
            if (timeout)                 state_next = FAIL;
            else if (fe && idx == 4'd9)  state_next = ACK;
         end
         ACK: begin
            if (timeout)  state_next = FAIL;
            else if (fe)  state_next = data_s ? FAIL : WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (timeout)              state_next = FAIL;
            else if (clk_s && data_s) state_next = DONE;
         end
         DONE: begin
            tx_done    = 1'b1;
            state_next = IDLE;
         end
         FAIL: begin
            tx_error   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Frame shifts out LSB first; the open-collector drive is the inverse of the bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inh_cnt  <= '0;
         to_cnt   <= '0;
         idx      <= '0;
         shift    <= '0;
         data_bit <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               data_bit <= 1'b0;
               if (tx_valid) begin
                  shift   <= {~^tx_data, tx_data};
                  inh_cnt <= '0;
               end
            end
            INHIBIT: inh_cnt <= inh_cnt + 1'b1;
            RELEASE: begin
               to_cnt   <= '0;
               idx      <= '0;
               data_bit <= 1'b1;
            end
            SEND, ACK, WAIT_IDLE: begin
               if (to_cnt != TO_W'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
               if (state == SEND && fe) begin
                  idx <= idx + 1'b1;
                  if (idx == 4'd9) begin
                     data_bit <= 1'b0;
                  end else begin
                     data_bit <= ~shift[0];
                     shift    <= shift >> 1;
                  end
               end
            end
            default: data_bit <= 1'b0;
         endcase
      end
   end

endmodule
